tv_sync_gen: RTL and testbench
==============================

Name: tv_sync_gen

Overview:
- Composite-TV timing generator: the stage directly upstream of the VPU pixel pipeline.
- Produces the horizontal/vertical pixel counters, the horizontal blanking strobe, the vertical blanking flag and the composite sync level that the VPU consumes. The VPU uses these for cache readout, DMA triggering, visible-line windows and tvout[0].
- Timing is progressive, one PAL-like 312-line field per frame, advanced by a pixel-rate clock enable.

Parameters:
- H_TOTAL, 384, pixel clocks per line (64 us at 6 MHz); must be even and ≤ 512.
- H_SYNC, 28, line sync pulse width in pixel clocks.
- H_BLANK, 72, horizontal blanking length from line start; includes the sync pulse; H_BLANK > H_SYNC.
- V_TOTAL, 312, lines per field; ≤ 512.
- V_SYNC, 3, broad-pulse (vertical sync) lines, starting at line 0.
- V_EQ, 2, equalising lines immediately after the vertical sync lines.
- V_BLANK, 24, vertically blanked lines from line 0; V_BLANK ≥ V_SYNC+V_EQ.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-low.
- ce  in  1  pixel enable; state advances only on clk edges with ce=1.
- cntHS  out  9  horizontal counter, 0..H_TOTAL-1.
- cntVS  out  9  line counter, 0..V_TOTAL-1.
- hsync  out  1  high while cntHS < H_BLANK (horizontal blanking interval).
- vbl  out  1  high while cntVS < V_BLANK.
- out_sync  out  1  composite sync level; 0 = sync tip, 1 = black/video.
- frame_start  out  1  one-ce-cycle pulse while cntHS=0 and cntVS=0.

Behaviour:
- Asynchronous reset while rst=0. Reset values are cntHS=H_TOTAL-1, cntVS=V_TOTAL-1, hsync=0, vbl=0, out_sync=1, frame_start=0. These equal the decode of the last pixel of the field, so the first ce after release yields (0,0).
- Reset asserted mid-line or mid-field: outputs jump immediately to the reset values. No partial pulse is held.
- Counters on each ce:
  - If cntHS=H_TOTAL-1, then cntHS←0; otherwise cntHS←cntHS+1.
  - On the cntHS wrap, if cntVS=V_TOTAL-1, then cntVS←0; otherwise cntVS←cntVS+1.
  - Both counters are 9-bit unsigned and never exceed their TOTAL-1.
- ce=0: every register, including frame_start, holds its value. frame_start therefore stays high across ce=0 cycles while the counters sit at (0,0).
- All outputs are registers decoded from the next counter values. In any cycle they correspond exactly to the cntHS/cntVS presented in that cycle, with no combinational path from counters to outputs (glitch-free out_sync).
- Let HALF = H_TOTAL/2. Line classes by cntVS:
  - Broad lines, cntVS < V_SYNC: out_sync=0 for cntHS in [0, HALF-H_SYNC-1] and [HALF, H_TOTAL-H_SYNC-1]; otherwise 1 (serration pulses).
  - Equalising lines, V_SYNC ≤ cntVS < V_SYNC+V_EQ: out_sync=0 for cntHS in [0, H_SYNC/2-1] and [HALF, HALF+H_SYNC/2-1]; otherwise 1.
  - Normal lines, all other lines: out_sync=0 for cntHS in [0, H_SYNC-1]; otherwise 1.
- hsync and vbl decode independently of line class. hsync is asserted on every line, including sync lines, so the VPU's per-line logic keeps running during vertical blanking.
- frame_start=1 exactly when the next state is (0,0). It falls on the next ce.
- Simultaneous H and V wrap at (H_TOTAL-1, V_TOTAL-1) happen in a single ce; there is no intermediate (0, V_TOTAL) state.

Test Plan:
- Reset release, ce=1 constant: cycle 0 after release shows cntHS=383, cntVS=311, out_sync=1. Next cycle shows (0,0), frame_start=1, hsync=1, vbl=1, out_sync=0. frame_start=0 one cycle later.
- Normal line 100: out_sync low for cntHS 0..27, high 28..383; hsync high for 0..71, low 72..383; vbl=0; exactly 384 cycles between line starts.
- Broad line 1: out_sync low 0..163, high 164..191, low 192..355, high 356..383. Equalising line 3: low 0..13 and 192..205, high elsewhere.
- Full field: cntVS wraps 311→0 exactly at cntHS 383→0. frame_start period = 119808 ce cycles. vbl high for lines 0..23 only.
- ce toggling 1-of-4 cycles: all outputs change only on ce cycles. Counts are identical to the ce=1 run, scaled by 4. frame_start high for 4 clk cycles.
- rst pulsed low at cntHS=200, cntVS=150: outputs immediately show (383,311, out_sync=1, hsync=0, vbl=0). After release, timing restarts from (0,0).

Source files
------------

// File: rtl/tv_sync_gen.sv
// Composite-TV timing generator: pixel/line counters plus blanking and composite sync.
// Every output is a register loaded from a decode of the next counter state, so none of them glitch.
module tv_sync_gen #(
  parameter int H_TOTAL = 384,
  parameter int H_SYNC  = 28,
  parameter int H_BLANK = 72,
  parameter int V_TOTAL = 312,
  parameter int V_SYNC  = 3,
  parameter int V_EQ    = 2,
  parameter int V_BLANK = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic [8:0] cntHS,
  output logic [8:0] cntVS,
  output logic       hsync,
  output logic       vbl,
  output logic       out_sync,
  output logic       frame_start
);

  localparam logic [8:0] H_LAST      = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);
  localparam logic [8:0] HALF        = 9'(H_TOTAL / 2);
  localparam logic [8:0] BROAD_A_END = 9'(H_TOTAL / 2 - H_SYNC);
  localparam logic [8:0] BROAD_B_END = 9'(H_TOTAL - H_SYNC);
  localparam logic [8:0] EQ_A_END    = 9'(H_SYNC / 2);
  localparam logic [8:0] EQ_B_END    = 9'(H_TOTAL / 2 + H_SYNC / 2);
  localparam logic [8:0] NORM_END    = 9'(H_SYNC);
  localparam logic [8:0] H_BLANK_END = 9'(H_BLANK);
  localparam logic [8:0] V_SYNC_END  = 9'(V_SYNC);
  localparam logic [8:0] V_EQ_END    = 9'(V_SYNC + V_EQ);
  localparam logic [8:0] V_BLANK_END = 9'(V_BLANK);

  logic [8:0] h_next_s;
  logic [8:0] v_next_s;

  // Sync level for a pixel position: broad lines carry serrations, equalising lines carry two half-width tips.
  function automatic logic sync_level(input logic [8:0] h, input logic [8:0] v);
    logic tip;
    if (v < V_SYNC_END) begin
      tip = (h < BROAD_A_END) || ((h >= HALF) && (h < BROAD_B_END));
    end else if (v < V_EQ_END) begin
      tip = (h < EQ_A_END) || ((h >= HALF) && (h < EQ_B_END));
    end else begin
      tip = (h < NORM_END);
    end
    return !tip;
  endfunction

  // Next counter state: advance on ce, with the line and field wraps taken in the same step.
  always_comb begin
    h_next_s = cntHS;
    v_next_s = cntVS;
    if (ce) begin
      if (cntHS == H_LAST) begin
        h_next_s = 9'd0;
        if (cntVS == V_LAST) begin
          v_next_s = 9'd0;
        end else begin
          v_next_s = cntVS + 9'd1;
        end
      end else begin
        h_next_s = cntHS + 9'd1;
        v_next_s = cntVS;
      end
    end else begin
      h_next_s = cntHS;
      v_next_s = cntVS;
    end
  end

  // Counter and output registers; reset lands on the last pixel of the field so the first ce gives (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntHS       <= H_LAST;
      cntVS       <= V_LAST;
      hsync       <= 1'b0;
      vbl         <= 1'b0;
      out_sync    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cntHS       <= h_next_s;
      cntVS       <= v_next_s;
      hsync       <= (h_next_s < H_BLANK_END);
      vbl         <= (v_next_s < V_BLANK_END);
      out_sync    <= sync_level(h_next_s, v_next_s);
      frame_start <= (h_next_s == 9'd0) && (v_next_s == 9'd0);
    end
  end

endmodule

// File: tb/tb_tv_sync_gen.sv
// Bench for tv_sync_gen: full-size instance for line-level timing, a small-parameter instance for field wraps.
// Expected outputs come from a position-in-field model: ce count since reset modulo pixels per field.
module tb_tv_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ce, rst_s, ce_s;
  logic [8:0] cnt_hs, cnt_vs, cnt_hs_s, cnt_vs_s;
  logic       hsync, vbl, out_sync, frame_start;
  logic       hsync_s, vbl_s, out_sync_s, frame_start_s;
  logic [21:0] obs_big, obs_small;

  int     checks = 0;
  int     errors = 0;
  longint k_big = 0;
  longint k_small = 0;

  tv_sync_gen dut (
    .clk(clk), .rst(rst), .ce(ce), .cntHS(cnt_hs), .cntVS(cnt_vs),
    .hsync(hsync), .vbl(vbl), .out_sync(out_sync), .frame_start(frame_start)
  );

  tv_sync_gen #(
    .H_TOTAL(16), .H_SYNC(4), .H_BLANK(6), .V_TOTAL(10), .V_SYNC(2), .V_EQ(1), .V_BLANK(4)
  ) dut_small (
    .clk(clk), .rst(rst_s), .ce(ce_s), .cntHS(cnt_hs_s), .cntVS(cnt_vs_s),
    .hsync(hsync_s), .vbl(vbl_s), .out_sync(out_sync_s), .frame_start(frame_start_s)
  );

  assign obs_big   = {cnt_hs, cnt_vs, hsync, vbl, out_sync, frame_start};
  assign obs_small = {cnt_hs_s, cnt_vs_s, hsync_s, vbl_s, out_sync_s, frame_start_s};

  // Expected {h, v, hsync, vbl, out_sync, frame_start} after k pixel enables since reset.
  function automatic logic [21:0] ref_model(input int ht, input int hsy, input int hb, input int vt,
                                            input int vsy, input int veq, input int vb, input longint k);
    longint field, p;
    int h, v, half;
    bit tip;
    field = longint'(ht) * longint'(vt);
    p     = (field - 1 + k) % field;
    h     = int'(p % ht);
    v     = int'(p / ht);
    half  = ht / 2;
    if (v < vsy)            tip = (h < half - hsy) || (h >= half && h < ht - hsy);
    else if (v < vsy + veq) tip = (h < hsy / 2) || (h >= half && h < half + hsy / 2);
    else                    tip = (h < hsy);
    return {9'(h), 9'(v), (h < hb), (v < vb), ~tip, (p == 0 && k > 0)};
  endfunction

  function automatic logic [21:0] exp_big(input longint k);
    return ref_model(384, 28, 72, 312, 3, 2, 24, k);
  endfunction

  function automatic logic [21:0] exp_small(input longint k);
    return ref_model(16, 4, 6, 10, 2, 1, 4, k);
  endfunction

  task automatic tick_big(input bit c);
    @(negedge clk) ce = c;
    @(posedge clk);
    if (c) k_big++;
    #1;
  endtask

  task automatic tick_small(input bit c);
    @(negedge clk) ce_s = c;
    @(posedge clk);
    if (c) k_small++;
    #1;
  endtask

  task automatic test_reset;
    logic [21:0] rst_val;
    rst_val = {9'd383, 9'd311, 1'b0, 1'b0, 1'b1, 1'b0};
    rst = 1'b0; ce = 1'b1; k_big = 0;
    #17;
    checks++;
    if (obs_big !== rst_val) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs_big, rst_val); end
    @(negedge clk) begin rst = 1'b1; ce = 1'b0; end
    #1;
    checks++;
    if (obs_big !== rst_val) begin errors++; $display("FAIL release_cycle0 got=%h exp=%h", obs_big, rst_val); end
    tick_big(1'b1);
    checks++;
    if (obs_big !== {9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL first_pixel got=%h exp=%h", obs_big, {9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1});
    end
    tick_big(1'b1);
    checks++;
    if (obs_big !== {9'd1, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL frame_start_fall got=%h exp=%h", obs_big, {9'd1, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    end
  endtask

  // Runs ce=1 through broad, equalising and normal lines up to (200,150), checking every pixel.
  task automatic test_lines;
    longint start_100, start_101;
    logic [21:0] e;
    start_100 = -1; start_101 = -1;
    while (k_big < 150 * 384 + 201) begin
      tick_big(1'b1);
      e = exp_big(k_big);
      checks++;
      if (obs_big !== e) begin
        errors++;
        if (errors < 20) $display("FAIL line_pixel k=%0d got=%h exp=%h", k_big, obs_big, e);
      end
      if (cnt_hs == 9'd0 && cnt_vs == 9'd100) start_100 = k_big;
      if (cnt_hs == 9'd0 && cnt_vs == 9'd101) start_101 = k_big;
    end
    checks++;
    if (start_101 - start_100 !== 384) begin
      errors++; $display("FAIL line_period got=%0d exp=384", start_101 - start_100);
    end
  endtask

  task automatic test_midreset;
    logic [21:0] rst_val, e;
    rst_val = {9'd383, 9'd311, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_big !== exp_big(k_big)) begin errors++; $display("FAIL pre_reset got=%h exp=%h", obs_big, exp_big(k_big)); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs_big !== rst_val) begin errors++; $display("FAIL async_reset got=%h exp=%h", obs_big, rst_val); end
    @(posedge clk); #1;
    checks++;
    if (obs_big !== rst_val) begin errors++; $display("FAIL reset_with_ce got=%h exp=%h", obs_big, rst_val); end
    @(negedge clk) begin ce = 1'b0; rst = 1'b1; end
    k_big = 0;
    for (int i = 0; i < 500; i++) begin
      tick_big(1'b1);
      e = exp_big(k_big);
      checks++;
      if (obs_big !== e) begin
        errors++;
        if (errors < 20) $display("FAIL restart k=%0d got=%h exp=%h", k_big, obs_big, e);
      end
    end
  endtask

  task automatic test_random_ce;
    logic [21:0] e;
    for (int i = 0; i < 3000; i++) begin
      tick_big($urandom_range(0, 3) == 0);
      e = exp_big(k_big);
      checks++;
      if (obs_big !== e) begin
        errors++;
        if (errors < 20) $display("FAIL random_ce k=%0d got=%h exp=%h", k_big, obs_big, e);
      end
    end
  endtask

  // Small instance: three fields at ce=1, wrap and frame_start period.
  task automatic test_full_field;
    logic [21:0] e;
    longint last_fs;
    int periods;
    rst_s = 1'b0; ce_s = 1'b0; k_small = 0;
    @(negedge clk) rst_s = 1'b1;
    last_fs = -1; periods = 0;
    for (int i = 0; i < 3 * 160 + 5; i++) begin
      tick_small(1'b1);
      e = exp_small(k_small);
      checks++;
      if (obs_small !== e) begin
        errors++;
        if (errors < 20) $display("FAIL field_pixel k=%0d got=%h exp=%h", k_small, obs_small, e);
      end
      if (frame_start_s) begin
        if (last_fs >= 0) begin
          periods++;
          checks++;
          if (k_small - last_fs !== 160) begin
            errors++; $display("FAIL frame_period got=%0d exp=160", k_small - last_fs);
          end
        end
        last_fs = k_small;
      end
    end
    checks++;
    if (periods !== 3) begin errors++; $display("FAIL frame_count got=%0d exp=3", periods); end
  endtask

  task automatic test_ce_quarter;
    logic [21:0] e;
    int run, runs;
    bit seen_rise;
    run = 0; runs = 0; seen_rise = 1'b0;
    for (int i = 0; i < 2 * 160 * 4 + 16; i++) begin
      tick_small(i % 4 == 0);
      e = exp_small(k_small);
      checks++;
      if (obs_small !== e) begin
        errors++;
        if (errors < 20) $display("FAIL quarter_pixel k=%0d got=%h exp=%h", k_small, obs_small, e);
      end
      if (frame_start_s) begin
        if (run == 0 && (i % 4 == 0)) seen_rise = 1'b1;
        run++;
      end else begin
        if (seen_rise && run != 0) begin
          runs++;
          checks++;
          if (run !== 4) begin errors++; $display("FAIL fs_width got=%0d exp=4", run); end
        end
        run = 0;
      end
    end
    checks++;
    if (runs !== 2) begin errors++; $display("FAIL fs_runs got=%0d exp=2", runs); end
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; rst_s = 1'b0; ce_s = 1'b0;
    test_reset();
    test_lines();
    test_midreset();
    test_random_ce();
    test_full_field();
    test_ce_quarter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
